qdiv_seq: RTL

QDIV_SEQ -- requirements
Module: qdiv_seq

---
 rtl/qdiv_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/qdiv_seq.sv
// Sequential signed fixed-point divider (Qm.n), restoring algorithm,
// fixed latency with saturation and divide-by-zero reporting.
module qdiv_seq #(
   parameter int N = 16,
   parameter int Q = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c,
   output logic         busy,
   output logic         done,
   output logic         ovf,
   output logic         dz
);

   localparam int W  = N + Q;
   localparam int CW = $clog2(W + 1);

   localparam logic [N-1:0]  POS_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  NEG_MIN = {1'b1, {(N-1){1'b0}}};
   localparam logic [W-1:0]  MAG_LIM = {{Q{1'b0}}, NEG_MIN};
   localparam logic [CW-1:0] LAST    = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    dvd;
   logic [N-1:0]    dvs;
   logic [N-1:0]    rem;
   logic            neg;
   logic            a_neg;
   logic            b_zero;

   logic [N-1:0]    a_mag;
   logic [N-1:0]    b_mag;
   logic [N:0]      rem_sh;
   logic            rem_ge;

   always_comb begin
      a_mag  = a[N-1] ? (~a + 1'b1) : a;
      b_mag  = b[N-1] ? (~b + 1'b1) : b;
      rem_sh = {rem, dvd[W-1]};
      rem_ge = rem_sh >= {1'b0, dvs};
   end

   // dvd holds the shifted dividend and collects quotient bits from the LSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         dvd    <= '0;
         dvs    <= '0;
         rem    <= '0;
         neg    <= 1'b0;
         a_neg  <= 1'b0;
         b_zero <= 1'b0;
         c      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         dz     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  dvd    <= {a_mag, {Q{1'b0}}};
                  dvs    <= b_mag;
                  rem    <= '0;
                  cnt    <= '0;
                  neg    <= a[N-1] ^ b[N-1];
                  a_neg  <= a[N-1];
                  b_zero <= (b == '0);
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               dvd <= {dvd[W-2:0], rem_ge};
               rem <= rem_ge ? (rem_sh[N-1:0] - dvs) : rem_sh[N-1:0];
               cnt <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= FIX;
            end
            FIX: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
               if (b_zero) begin
                  c   <= a_neg ? NEG_MIN : POS_MAX;
                  ovf <= 1'b0;
                  dz  <= 1'b1;
               end else if (!neg && dvd >= MAG_LIM) begin
                  c   <= POS_MAX;
                  ovf <= 1'b1;
                  dz  <= 1'b0;
               end else if (neg && dvd > MAG_LIM) begin
                  c   <= NEG_MIN;
                  ovf <= 1'b1;
                  dz  <= 1'b0;
               end else begin
                  c   <= neg ? (~dvd[N-1:0] + 1'b1) : dvd[N-1:0];
                  ovf <= 1'b0;
                  dz  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
